// File: rtl/gp_fifo_pkg.sv
// ============================================================================
// Module      : gp_fifo_pkg
// Description : Shared sizing constants and word type for the NI FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gp_fifo_pkg;

  localparam int GP_FIFO_DATA_W = 64;
  localparam int GP_FIFO_DEPTH  = 16;
  localparam int GP_FIFO_PTR_W  = 4;

  typedef logic [GP_FIFO_DATA_W-1:0] gp_word_t;

endpackage : gp_fifo_pkg

`default_nettype wire

// File: rtl/gp_fifo_mem.sv
// ============================================================================
// Module      : gp_fifo_mem
// Description : Register array with synchronous write and registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gp_fifo_mem
  import gp_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = GP_FIFO_DATA_W,
  parameter int DEPTH      = GP_FIFO_DEPTH,
  parameter int ADDR_W     = GP_FIFO_PTR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [ADDR_W-1:0]     wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_W-1:0]     rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  // Array contents are deliberately left unreset; only the read register is.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule : gp_fifo_mem

`default_nettype wire

// File: rtl/general_purpose_fifo.sv
// ============================================================================
// Module      : general_purpose_fifo
// Description : Single-clock 16x64 FIFO between NI packetiser and router port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module general_purpose_fifo
  import gp_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = GP_FIFO_DATA_W,
  parameter int DEPTH      = GP_FIFO_DEPTH,
  parameter int PTR_W      = GP_FIFO_PTR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  error,
  output logic                  full,
  output logic                  empty,
  output logic [PTR_W:0]        ocup
);

  localparam logic [PTR_W:0] c_FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   ocup_q, ocup_d;
  logic             error_q, error_d;
  logic             w_we_ok;
  logic             w_re_ok;

  // A full FIFO still accepts a write when a pop frees a slot on the same edge;
  // an empty FIFO never pops, even if a write lands on that edge.
  assign w_we_ok = write_en && (!full || read_en);
  assign w_re_ok = read_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ocup_d   = ocup_q;
    if (w_we_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (w_re_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (w_we_ok && !w_re_ok) begin
      ocup_d = ocup_q + 1'b1;
    end else if (w_re_ok && !w_we_ok) begin
      ocup_d = ocup_q - 1'b1;
    end
    error_d = (write_en && !w_we_ok) || (read_en && !w_re_ok);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ocup_q   <= '0;
      error_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ocup_q   <= ocup_d;
      error_q  <= error_d;
    end
  end

  gp_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (PTR_W)
  ) u_mem (
    .clk       (clk),
    .rst       (reset),
    .wr_en_i   (w_we_ok),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (data_in),
    .rd_en_i   (w_re_ok),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (data_out)
  );

  assign ocup  = ocup_q;
  assign error = error_q;
  assign full  = (ocup_q == c_FULL_COUNT);
  assign empty = (ocup_q == '0);

endmodule : general_purpose_fifo

`default_nettype wire

// File: tb/tb_general_purpose_fifo.sv
// ============================================================================
// Module      : tb_general_purpose_fifo
// Description : Directed scoreboard bench for general_purpose_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_general_purpose_fifo;
  import gp_fifo_pkg::*;

  logic        clk;
  logic        reset;
  logic        write_en;
  logic        read_en;
  gp_word_t    data_in;
  gp_word_t    data_out;
  logic        error;
  logic        full;
  logic        empty;
  logic [4:0]  ocup;

  int vectors;
  int miscompares;

  gp_word_t    sb_q[$];
  gp_word_t    exp_dout;
  logic        exp_err;

  general_purpose_fifo dut (
    .clk      (clk),
    .reset    (reset),
    .write_en (write_en),
    .read_en  (read_en),
    .data_in  (data_in),
    .data_out (data_out),
    .error    (error),
    .full     (full),
    .empty    (empty),
    .ocup     (ocup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".data_out"}, data_out, exp_dout);
    chk({tag, ".ocup"}, 64'(ocup), 64'(sb_q.size()));
    chk({tag, ".full"}, 64'(full), 64'(sb_q.size() == 16));
    chk({tag, ".empty"}, 64'(empty), 64'(sb_q.size() == 0));
    chk({tag, ".error"}, 64'(error), 64'(exp_err));
  endtask

  // One clock edge with the given controls; reference model updated, then all outputs checked.
  task automatic step(input string tag, input logic we, input logic re, input gp_word_t din);
    bit we_ok, re_ok;
    write_en = we;
    read_en  = re;
    data_in  = din;
    @(posedge clk);
    #1;
    we_ok = we && (sb_q.size() < 16 || re);
    re_ok = re && (sb_q.size() > 0);
    exp_err = (we && !we_ok) || (re && !re_ok);
    if (re_ok) exp_dout = sb_q.pop_front();
    if (we_ok) sb_q.push_back(din);
    write_en = 1'b0;
    read_en  = 1'b0;
    chk_all(tag);
  endtask

  task automatic model_reset();
    sb_q.delete();
    exp_dout = '0;
    exp_err  = 1'b0;
  endtask

  initial begin
    gp_word_t w;
    vectors     = 0;
    miscompares = 0;
    write_en = 1'b0;
    read_en  = 1'b0;
    data_in  = '0;
    reset    = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    reset = 1'b0;

    // Four directed words, then drain in order
    step("w0", 1, 0, 64'hA5A5A5A5A5A5A5A5);
    step("w1", 1, 0, 64'hA5A5A5A5A5A5A1A5);
    step("w2", 1, 0, 64'hA5A5A5A5A5A5A4A5);
    step("w3", 1, 0, 64'h35A5A5A5A5A5A5A5);
    chk("ocup_after_4", 64'(ocup), 64'd4);
    step("r0", 0, 1, '0);
    chk("first_pop", data_out, 64'hA5A5A5A5A5A5A5A5);
    step("r1", 0, 1, '0);
    step("r2", 0, 1, '0);
    step("r3", 0, 1, '0);
    chk("last_pop", data_out, 64'h35A5A5A5A5A5A5A5);
    chk("empty_after_drain", 64'(empty), 64'd1);

    // Fill to 16, overflow attempt, then full write+read
    for (int i = 0; i < 16; i++) begin
      w = {32'h1000_0000 + 32'(i), 32'hCAFE_0000 + 32'(i)};
      step("fill", 1, 0, w);
    end
    chk("full_at_16", 64'(full), 64'd1);
    step("overflow", 1, 0, 64'hDEAD_BEEF_DEAD_BEEF);
    chk("overflow_err", 64'(error), 64'd1);
    step("after_overflow", 0, 0, '0);
    chk("err_not_sticky", 64'(error), 64'd0);
    step("full_wr_rd", 1, 1, 64'h0123_4567_89AB_CDEF);
    chk("full_wr_rd_ocup", 64'(ocup), 64'd16);
    for (int i = 0; i < 16; i++) begin
      step("drain", 0, 1, '0);
      chk("no_dead_word", 64'(data_out == 64'hDEAD_BEEF_DEAD_BEEF), 64'd0);
    end
    chk("drain_tail", data_out, 64'h0123_4567_89AB_CDEF);

    // Underflow and empty write+read
    step("underflow", 0, 1, '0);
    chk("underflow_dout_held", data_out, 64'h0123_4567_89AB_CDEF);
    step("empty_wr_rd", 1, 1, 64'h5555_AAAA_5555_AAAA);
    chk("empty_wr_rd_ocup", 64'(ocup), 64'd1);
    step("pop_single", 0, 1, '0);

    // Sustained push/pop around half-full to exercise pointer wrap
    for (int i = 0; i < 8; i++) step("pre", 1, 0, {32'(i), 32'hBEEF_0000});
    for (int i = 0; i < 40; i++) begin
      w = {$urandom, $urandom};
      step("wrap", 1, 1, w);
    end
    for (int i = 0; i < 8; i++) step("post", 0, 1, '0);

    // Asynchronous reset between edges while holding data
    for (int i = 0; i < 5; i++) step("pre_rst", 1, 0, {32'hF00D_0000, 32'(i)});
    step("pre_rst_rd", 0, 1, '0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk_all("async_reset");
    @(posedge clk);
    #1;
    chk_all("reset_held");
    reset = 1'b0;
    step("post_rst_w", 1, 0, 64'h7777_8888_9999_AAAA);
    step("post_rst_r", 0, 1, '0);
    chk("post_rst_data", data_out, 64'h7777_8888_9999_AAAA);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_general_purpose_fifo

`default_nettype wire
